// File: rtl/fir_dec_fifo_pkg.sv
// Shared DSP constants and helpers for the FIR output stages.
// Holds sample width, FIFO depth, warm-up length and control state type.
package fir_dec_fifo_pkg;

    localparam int DSP_W      = 19;
    localparam int DSP_DEPTH  = 4;
    localparam int DSP_WARMUP = 3;
    localparam int DSP_CNT_W  = $clog2(DSP_DEPTH) + 1;

    typedef enum logic {
        ST_WARM,
        ST_RUN
    } dec_state_e;

    // Phase advance within a decimation period of length mm+1.
    function automatic logic [1:0] next_phase(
        input logic [1:0] ph,
        input logic [1:0] mm
    );
        return (ph == mm) ? 2'd0 : ph + 2'd1;
    endfunction

endpackage

// File: rtl/fir_dec_fifo_sync_fifo.sv
// sync_fifo_fwft: first-word fall-through FIFO with registered storage.
// Ports: clk, rst, push/wdata, pop/rdata, count, full, empty.
module sync_fifo_fwft #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Guard against pops when empty and pushes when full without a pop.
    assign do_rd = pop && !empty;
    assign do_wr = push && (!full || do_rd);

    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + AW'(1);
            end
            if (do_rd) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_dec_fifo.sv
// FIR output warm-up discard, 1..4 decimation and FWFT output FIFO.
// Ports: clk, rst, in_valid/in_data, dec_m, out_valid/out_ready/out_data, count, ovf.
module fir_dec_fifo
    import fir_dec_fifo_pkg::*;
#(
    parameter int W      = DSP_W,
    parameter int DEPTH  = DSP_DEPTH,
    parameter int WARMUP = DSP_WARMUP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [W-1:0]           in_data,
    input  logic [1:0]             dec_m,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf
);

    localparam int WCW = $clog2(WARMUP + 2);
    localparam dec_state_e ST_INIT = (WARMUP == 0) ? ST_RUN : ST_WARM;

    dec_state_e     state;
    dec_state_e     state_n;
    logic [WCW-1:0] wcnt;
    logic [WCW-1:0] wcnt_n;
    logic [1:0]     phase;
    logic [1:0]     phase_n;
    logic [1:0]     m_reg;
    logic [1:0]     m_n;
    logic [1:0]     mval;
    logic           accept;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            wcnt  <= '0;
            phase <= '0;
            m_reg <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            phase <= phase_n;
            m_reg <= m_n;
        end
    end

    // A period begins at phase 0: that sample uses the live dec_m and
    // latches it, so later dec_m changes only affect the next period.
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        phase_n = phase;
        m_n     = m_reg;
        mval    = m_reg;
        accept  = 1'b0;
        unique case (state)
            ST_WARM: begin
                if (in_valid) begin
                    wcnt_n = wcnt + WCW'(1);
                    if (wcnt_n == WCW'(WARMUP)) begin
                        state_n = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    if (phase == 2'd0) begin
                        mval   = dec_m;
                        m_n    = dec_m;
                        accept = 1'b1;
                    end
                    phase_n = next_phase(phase, mval);
                end
            end
        endcase
    end

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = accept && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (accept && full && !pop) begin
            ovf <= 1'b1;
        end
    end

    sync_fifo_fwft #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (out_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: doc/fir_dec_fifo.md
FIR_DEC_FIFO -- requirements
Module: fir_dec_fifo

Interface
REQ-001 Parameter W, default 19: sample width, equal to the FIR output width.
REQ-002 Parameter DEPTH, default 4: FIFO entries, a power of two.
REQ-003 Parameter WARMUP, default 3: post-reset input samples discarded while the FIR pipeline fills.
REQ-004 The block SHALL run on one clock; reset is asynchronous and active-high.
REQ-005 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  FIR output sample present this cycle.
- in_data  in  W  unsigned FIR output sample.
- dec_m  in  2  decimation factor minus one (factor M = dec_m+1, range 1..4).
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  W  head entry.
- count  out  clog2(DEPTH)+1  FIFO occupancy.
- ovf  out  1  sticky overflow flag.

Function
REQ-006 Warm-up: a counter 0..WARMUP SHALL increment on each in_valid until it reaches WARMUP; samples arriving while counter<WARMUP SHALL be dropped and SHALL NOT advance the phase counter.
REQ-007 Decimation: after warm-up, a phase counter 0..M-1 SHALL advance on each in_valid and wrap to 0 after M-1; a sample SHALL be accepted only when in_valid=1 and phase=0.
REQ-008 dec_m SHALL be latched into m_reg at the first post-warm-up in_valid and at every wrap to phase 0; a mid-period dec_m change SHALL NOT alter the current period.
REQ-009 Push SHALL occur when a sample is accepted and (count<DEPTH or pop occurs the same cycle).
REQ-010 If an accepted sample finds count=DEPTH with no pop that cycle, the sample SHALL be dropped, FIFO contents SHALL be unchanged, and ovf SHALL be set to 1 and held until reset.
REQ-011 out_valid SHALL equal (count!=0); out_data SHALL be the oldest entry (first-word fall-through, registered storage); out_data is don't-care when out_valid=0.
REQ-012 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-013 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-014 Push into an empty FIFO SHALL raise out_valid on the cycle after the push; there is no combinational bypass from in_data to out_data.
REQ-015 out_ready while empty SHALL have no effect.
REQ-016 Data SHALL pass unmodified: no rounding, scaling or sign handling.
REQ-017 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.

Reset
REQ-018 Asserting rst SHALL immediately clear the warm-up counter, phase, m_reg (to 0), pointers, count, out_valid and ovf, independent of clk.
REQ-019 Reset mid-operation SHALL discard all stored entries and restart warm-up.
REQ-020 Storage array contents need not be reset.

Structure
REQ-021 W, DEPTH and WARMUP defaults and the count width SHALL be constants in the shared DSP package used by the FIR stages.
REQ-022 The FIFO storage and pointers SHALL form one sub-module, sync_fifo_fwft; the warm-up and decimation control SHALL sit in fir_dec_fifo.

Verification
REQ-023 Reset, then in_valid=1 with in_data=1,2,3,4,5,6 and dec_m=0, out_ready=1 -> samples 1..3 dropped; out_data=4,5,6 each one cycle after input; ovf=0.
REQ-024 After warm-up, dec_m=2 (M=3), in_data=10..18 continuous -> only 10,13,16 emitted.
REQ-025 dec_m=0, out_ready=0, six post-warm-up samples A..F -> count=4, ovf=1, entries A..D retained; then out_ready=1 -> A,B,C,D in order, then out_valid=0.
REQ-026 FIFO full with out_ready=1 and in_valid=1 in the same cycle -> pop and push both occur, count stays 4, ovf stays 0.
REQ-027 dec_m changed 1->3 at phase 1 -> current period completes at M=2, next period uses M=4.
REQ-028 rst asserted between clock edges with count=3 -> count=0, out_valid=0, ovf=0 immediately; the next three in_valid samples are dropped.
